// File: rtl/kronos_mem_arbiter_pkg.sv
// Shared types and widths for the Kronos memory arbiter.
package kronos_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_INSTR,
        ARB_DATA
    } arb_state_t;

    localparam int unsigned ARB_TIMEOUT_W = 16;
    localparam int unsigned ARB_ADDR_W    = 32;
    localparam int unsigned ARB_DATA_W    = 32;
    localparam int unsigned ARB_MASK_W    = 4;

endpackage : kronos_mem_arbiter_pkg

// File: rtl/kronos_mem_arbiter_if.sv
// Bundles the fetch port, the data port and the shared memory bus.
// slave: the arbiter's view. master: the surrounding core/memory view.
interface kronos_mem_arbiter_if;
    import kronos_mem_arbiter_pkg::*;

    // fetch port
    logic [ARB_ADDR_W-1:0] instr_addr;
    logic                  instr_req;
    logic [ARB_DATA_W-1:0] instr_data;
    logic                  instr_gnt;
    logic                  instr_err;

    // data port
    logic [ARB_ADDR_W-1:0] data_addr;
    logic                  data_rd_req;
    logic                  data_wr_req;
    logic [ARB_DATA_W-1:0] data_wr_data;
    logic [ARB_MASK_W-1:0] data_wr_mask;
    logic [ARB_DATA_W-1:0] data_rd_data;
    logic                  data_gnt;
    logic                  data_err;

    // shared memory bus
    logic [ARB_ADDR_W-1:0] mem_addr;
    logic [ARB_DATA_W-1:0] mem_wr_data;
    logic [ARB_MASK_W-1:0] mem_wr_mask;
    logic                  mem_rd_req;
    logic                  mem_wr_req;
    logic [ARB_DATA_W-1:0] mem_rd_data;
    logic                  mem_gnt;

    modport slave (
        input  instr_addr, instr_req,
        output instr_data, instr_gnt, instr_err,
        input  data_addr, data_rd_req, data_wr_req, data_wr_data, data_wr_mask,
        output data_rd_data, data_gnt, data_err,
        output mem_addr, mem_wr_data, mem_wr_mask, mem_rd_req, mem_wr_req,
        input  mem_rd_data, mem_gnt
    );

    modport master (
        output instr_addr, instr_req,
        input  instr_data, instr_gnt, instr_err,
        output data_addr, data_rd_req, data_wr_req, data_wr_data, data_wr_mask,
        input  data_rd_data, data_gnt, data_err,
        input  mem_addr, mem_wr_data, mem_wr_mask, mem_rd_req, mem_wr_req,
        output mem_rd_data, mem_gnt
    );

endinterface : kronos_mem_arbiter_if

// File: rtl/kronos_mem_arbiter.sv
// Kronos memory arbiter: shares one single-ported memory bus between the
// instruction-fetch port and the data (LSU/write-back) port.
// Optional watchdog: define KRONOS_MEM_ARB_TIMEOUT_EN to enable it.
module kronos_mem_arbiter
    import kronos_mem_arbiter_pkg::*;
#(
    parameter bit          DATA_FIRST = 1'b1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    kronos_mem_arbiter_if.slave   bus
);

    // Reject watchdog limits the 16-bit counter cannot represent.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("kronos_mem_arbiter: TIMEOUT out of range 1..65535");
    end

    arb_state_t state_q, state_d;
    logic       data_req;
    logic       done;

    assign data_req = bus.data_rd_req | bus.data_wr_req;

`ifdef KRONOS_MEM_ARB_TIMEOUT_EN
    localparam logic [ARB_TIMEOUT_W-1:0] TimeoutLim = ARB_TIMEOUT_W'(TIMEOUT);

    logic [ARB_TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                     timeout_hit;

    assign timeout_hit = (cnt_q == TimeoutLim);

    // Watchdog counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Ownership state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection, bus mux and grant/data routing back to the owner.
    always_comb begin
        state_d          = state_q;
        done             = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wr_data  = '0;
        bus.mem_wr_mask  = '0;
        bus.mem_rd_req   = 1'b0;
        bus.mem_wr_req   = 1'b0;
        bus.instr_gnt    = 1'b0;
        bus.instr_data   = '0;
        bus.instr_err    = 1'b0;
        bus.data_gnt     = 1'b0;
        bus.data_rd_data = '0;
        bus.data_err     = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (bus.instr_req && data_req) begin
                    state_d = DATA_FIRST ? ARB_DATA : ARB_INSTR;
                end else if (bus.instr_req) begin
                    state_d = ARB_INSTR;
                end else if (data_req) begin
                    state_d = ARB_DATA;
                end
            end

            ARB_INSTR: begin
                bus.mem_addr   = bus.instr_addr;
                bus.mem_rd_req = 1'b1;
                if (bus.mem_gnt) begin
                    bus.instr_gnt  = 1'b1;
                    bus.instr_data = bus.mem_rd_data;
                    done           = 1'b1;
                end
`ifdef KRONOS_MEM_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    bus.instr_err  = 1'b1;
                    bus.mem_rd_req = 1'b0;
                    done           = 1'b1;
                end
`endif
                if (done) begin
                    state_d = data_req ? ARB_DATA : ARB_IDLE;
                end
            end

            ARB_DATA: begin
                bus.mem_addr    = bus.data_addr;
                bus.mem_wr_data = bus.data_wr_data;
                bus.mem_wr_mask = bus.data_wr_mask;
                bus.mem_rd_req  = bus.data_rd_req;
                bus.mem_wr_req  = bus.data_wr_req;
                if (bus.mem_gnt) begin
                    bus.data_gnt     = 1'b1;
                    bus.data_rd_data = bus.mem_rd_data;
                    done             = 1'b1;
                end
`ifdef KRONOS_MEM_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    bus.data_err   = 1'b1;
                    bus.mem_rd_req = 1'b0;
                    bus.mem_wr_req = 1'b0;
                    done           = 1'b1;
                end
`endif
                if (done) begin
                    state_d = bus.instr_req ? ARB_INSTR : ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

`ifdef KRONOS_MEM_ARB_TIMEOUT_EN
    // Counter restarts on every new ownership and counts stalled cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ARB_IDLE || done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ARB_TIMEOUT_W'(1);
        end
    end
`endif

endmodule : kronos_mem_arbiter

// File: tb/tb_kronos_mem_arbiter.sv
// Directed self-checking bench for kronos_mem_arbiter (DATA_FIRST=1, TIMEOUT=4).
module tb_kronos_mem_arbiter;

    logic clk;
    logic rst;

    int unsigned n_cmp;
    int unsigned n_bad;

    kronos_mem_arbiter_if bus_if ();

    kronos_mem_arbiter #(
        .DATA_FIRST (1'b1),
        .TIMEOUT    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to the middle of the cycle; outputs are sampled here.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus_if.instr_addr   = '0;
        bus_if.instr_req    = 1'b0;
        bus_if.data_addr    = '0;
        bus_if.data_rd_req  = 1'b0;
        bus_if.data_wr_req  = 1'b0;
        bus_if.data_wr_data = '0;
        bus_if.data_wr_mask = '0;
        bus_if.mem_rd_data  = '0;
        bus_if.mem_gnt      = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        clear_inputs();

        // Reset state
        mid();
        check("rst_mem_rd_req", 32'(bus_if.mem_rd_req), 32'd0);
        check("rst_mem_wr_req", 32'(bus_if.mem_wr_req), 32'd0);
        check("rst_instr_gnt",  32'(bus_if.instr_gnt),  32'd0);
        check("rst_data_gnt",   32'(bus_if.data_gnt),   32'd0);
        check("rst_mem_addr",   bus_if.mem_addr,        32'd0);
        step();
        rst = 1'b0;
        step();

        // Single fetch, mem_gnt three cycles after the bus request
        bus_if.instr_addr = 32'h0000_0100;
        bus_if.instr_req  = 1'b1;
        mid();
        check("fetch_idle_cycle", 32'(bus_if.mem_rd_req), 32'd0);
        step();
        mid();
        check("fetch_mem_rd_req", 32'(bus_if.mem_rd_req), 32'd1);
        check("fetch_mem_addr",   bus_if.mem_addr,        32'h0000_0100);
        check("fetch_mem_mask",   32'(bus_if.mem_wr_mask), 32'd0);
        check("fetch_wait_gnt",   32'(bus_if.instr_gnt),  32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            mid();
            check("fetch_wait_gnt", 32'(bus_if.instr_gnt), 32'd0);
        end
        step();
        bus_if.mem_gnt     = 1'b1;
        bus_if.mem_rd_data = 32'hDEAD_BEEF;
        mid();
        check("fetch_instr_gnt",  32'(bus_if.instr_gnt), 32'd1);
        check("fetch_instr_data", bus_if.instr_data,     32'hDEAD_BEEF);
        check("fetch_data_gnt",   32'(bus_if.data_gnt),  32'd0);
        check("fetch_data_rd",    bus_if.data_rd_data,   32'd0);
        step();
        bus_if.mem_gnt   = 1'b0;
        bus_if.instr_req = 1'b0;
        mid();
        check("fetch_back_idle", 32'(bus_if.mem_rd_req), 32'd0);

        // Spurious mem_gnt while idle
        step();
        bus_if.mem_gnt     = 1'b1;
        bus_if.mem_rd_data = 32'hAAAA_5555;
        mid();
        check("spur_instr_gnt",  32'(bus_if.instr_gnt), 32'd0);
        check("spur_data_gnt",   32'(bus_if.data_gnt),  32'd0);
        check("spur_instr_data", bus_if.instr_data,     32'd0);
        step();
        bus_if.mem_gnt = 1'b0;
        mid();
        check("spur_still_idle", 32'({bus_if.mem_rd_req, bus_if.mem_wr_req}), 32'd0);

        // Simultaneous fetch and store: store first, then fetch with no bubble
        step();
        bus_if.instr_addr   = 32'h0000_0200;
        bus_if.instr_req    = 1'b1;
        bus_if.data_addr    = 32'h0000_8000;
        bus_if.data_wr_req  = 1'b1;
        bus_if.data_wr_data = 32'h1234_5678;
        bus_if.data_wr_mask = 4'hF;
        mid();
        check("sim_idle_cycle", 32'(bus_if.mem_wr_req), 32'd0);
        step();
        mid();
        check("sim_store_wr_req", 32'(bus_if.mem_wr_req),  32'd1);
        check("sim_store_rd_req", 32'(bus_if.mem_rd_req),  32'd0);
        check("sim_store_mask",   32'(bus_if.mem_wr_mask), 32'h0000_000F);
        check("sim_store_addr",   bus_if.mem_addr,         32'h0000_8000);
        check("sim_store_wdata",  bus_if.mem_wr_data,      32'h1234_5678);
        step();
        bus_if.mem_gnt = 1'b1;
        mid();
        check("sim_data_gnt",   32'(bus_if.data_gnt),  32'd1);
        check("sim_instr_quiet", 32'(bus_if.instr_gnt), 32'd0);
        step();
        bus_if.mem_gnt     = 1'b0;
        bus_if.data_wr_req = 1'b0;
        mid();
        check("sim_fetch_addr",   bus_if.mem_addr,        32'h0000_0200);
        check("sim_fetch_rd_req", 32'(bus_if.mem_rd_req), 32'd1);
        check("sim_fetch_wr_req", 32'(bus_if.mem_wr_req), 32'd0);
        step();
        bus_if.mem_gnt     = 1'b1;
        bus_if.mem_rd_data = 32'h0BAD_F00D;
        mid();
        check("sim_instr_gnt",  32'(bus_if.instr_gnt), 32'd1);
        check("sim_instr_data", bus_if.instr_data,     32'h0BAD_F00D);
        step();
        bus_if.mem_gnt   = 1'b0;
        bus_if.instr_req = 1'b0;
        step();

        // Continuous contention: grants alternate D,I,D,I,D,I
        bus_if.instr_addr  = 32'h0000_0300;
        bus_if.instr_req   = 1'b1;
        bus_if.data_addr   = 32'h0000_9000;
        bus_if.data_rd_req = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            bus_if.mem_gnt     = 1'b1;
            bus_if.mem_rd_data = 32'h0000_1000 + 32'(i);
            mid();
            if (i % 2 == 0) begin
                check("cont_data_gnt",  32'(bus_if.data_gnt),  32'd1);
                check("cont_instr_gnt", 32'(bus_if.instr_gnt), 32'd0);
                check("cont_data_rd",   bus_if.data_rd_data,   32'h0000_1000 + 32'(i));
                check("cont_instr_rd",  bus_if.instr_data,     32'd0);
            end else begin
                check("cont_data_gnt",  32'(bus_if.data_gnt),  32'd0);
                check("cont_instr_gnt", 32'(bus_if.instr_gnt), 32'd1);
                check("cont_instr_rd",  bus_if.instr_data,     32'h0000_1000 + 32'(i));
                check("cont_data_rd",   bus_if.data_rd_data,   32'd0);
            end
            step();
        end

        // Reset mid-transaction: data port owns the bus, no mem_gnt yet
        bus_if.mem_gnt   = 1'b0;
        bus_if.instr_req = 1'b0;
        mid();
        check("rmt_in_data", 32'(bus_if.mem_rd_req), 32'd1);
        #1;
        rst            = 1'b1;
        bus_if.mem_gnt = 1'b1;
        #1;
        check("rmt_rd_req_drop", 32'(bus_if.mem_rd_req), 32'd0);
        check("rmt_wr_req_drop", 32'(bus_if.mem_wr_req), 32'd0);
        check("rmt_no_data_gnt", 32'(bus_if.data_gnt),   32'd0);
        step();
        bus_if.mem_gnt     = 1'b0;
        bus_if.data_rd_req = 1'b0;
        step();
        rst = 1'b0;
        bus_if.instr_addr = 32'h0000_0500;
        bus_if.instr_req  = 1'b1;
        mid();
        check("rmt_idle_after", 32'(bus_if.mem_rd_req), 32'd0);
        step();
        mid();
        check("rmt_fetch_start", 32'(bus_if.mem_rd_req), 32'd1);

`ifdef KRONOS_MEM_ARB_TIMEOUT_EN
        // Watchdog: no mem_gnt, err fires on the fifth INSTR cycle (count 4)
        for (int k = 1; k <= 4; k++) begin
            step();
            mid();
            if (k < 4) begin
                check("to_wait_err",    32'(bus_if.instr_err),  32'd0);
                check("to_wait_rd_req", 32'(bus_if.mem_rd_req), 32'd1);
            end else begin
                check("to_instr_err",   32'(bus_if.instr_err),  32'd1);
                check("to_instr_gnt",   32'(bus_if.instr_gnt),  32'd0);
                check("to_rd_req_drop", 32'(bus_if.mem_rd_req), 32'd0);
                check("to_data_err",    32'(bus_if.data_err),   32'd0);
            end
        end
        step();
        mid();
        check("to_back_idle", 32'(bus_if.mem_rd_req), 32'd0);
        check("to_err_pulse", 32'(bus_if.instr_err),  32'd0);
        // Retry: mem_gnt arrives exactly at the timeout count and wins
        for (int k = 0; k <= 4; k++) begin
            step();
            if (k == 4) begin
                bus_if.mem_gnt     = 1'b1;
                bus_if.mem_rd_data = 32'hCAFE_0004;
            end
            mid();
        end
        check("to_race_gnt",  32'(bus_if.instr_gnt), 32'd1);
        check("to_race_err",  32'(bus_if.instr_err), 32'd0);
        check("to_race_data", bus_if.instr_data,     32'hCAFE_0004);
`else
        // Without the watchdog a stalled fetch simply keeps waiting
        for (int k = 1; k <= 8; k++) begin
            step();
            mid();
            check("stall_rd_req", 32'(bus_if.mem_rd_req), 32'd1);
            check("stall_err",    32'({bus_if.instr_err, bus_if.data_err}), 32'd0);
        end
        step();
        bus_if.mem_gnt     = 1'b1;
        bus_if.mem_rd_data = 32'hCAFE_0008;
        mid();
        check("stall_gnt",  32'(bus_if.instr_gnt), 32'd1);
        check("stall_data", bus_if.instr_data,     32'hCAFE_0008);
`endif
        step();
        bus_if.mem_gnt   = 1'b0;
        bus_if.instr_req = 1'b0;
        mid();
        check("end_idle", 32'({bus_if.mem_rd_req, bus_if.mem_wr_req}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_kronos_mem_arbiter
